instr_fetch: RTL and testbench

Instruction fetch unit sitting on the output side of the program counter register: it consumes the current PC, issues in-order requests to instruction memory, buffers returned instructions, and hands them to decode over a valid/ready handshake. It also drives the PC register's next-value input, holding the PC on a stall and steering it on a redirect, since that register loads unconditionally every cycle.

---
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: PC register link, redirect, instruction memory request/response and decode handshake.
interface instr_fetch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PC_i;
  logic [WIDTH-1:0] PC_Next_o;
  logic             Redirect_i;
  logic [WIDTH-1:0] Redirect_PC_i;
  logic             IMem_Req_Valid_o;
  logic             IMem_Req_Ready_i;
  logic [WIDTH-1:0] IMem_Addr_o;
  logic             IMem_Rsp_Valid_i;
  logic [WIDTH-1:0] IMem_Rsp_Data_i;
  logic             Instr_Valid_o;
  logic             Instr_Ready_i;
  logic [WIDTH-1:0] Instr_o;
  logic [WIDTH-1:0] Instr_PC_o;

  modport master (
    input  PC_i, Redirect_i, Redirect_PC_i, IMem_Req_Ready_i,
           IMem_Rsp_Valid_i, IMem_Rsp_Data_i, Instr_Ready_i,
    output PC_Next_o, IMem_Req_Valid_o, IMem_Addr_o,
           Instr_Valid_o, Instr_o, Instr_PC_o
  );

  modport slave (
    output PC_i, Redirect_i, Redirect_PC_i, IMem_Req_Ready_i,
           IMem_Rsp_Valid_i, IMem_Rsp_Data_i, Instr_Ready_i,
    input  PC_Next_o, IMem_Req_Valid_o, IMem_Addr_o,
           Instr_Valid_o, Instr_o, Instr_PC_o
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: issues in-order memory requests from the PC, buffers responses in a circular
// buffer, hands them to decode over valid/ready, and drives the PC register's next value.
module instr_fetch #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [WIDTH-1:0] pc_d   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t fill_ptr_q, fill_ptr_d;
  ptr_t head_ptr_q, head_ptr_d;
  ptr_t occ_q, occ_d;
  ptr_t drop_q, drop_d;

  logic [AW-1:0] head_idx, alloc_idx, fill_idx;
  ptr_t          unfilled;
  logic          req_vld, accept, deq, rsp_drop, rsp_fill, rsp_take;

  assign head_idx  = head_ptr_q[AW-1:0];
  assign alloc_idx = alloc_ptr_q[AW-1:0];
  assign fill_idx  = fill_ptr_q[AW-1:0];
  assign unfilled  = alloc_ptr_q - fill_ptr_q;

  // Dropped responses still occupy a memory slot, so they count against buffer space.
  assign req_vld = rst && !bus.Redirect_i &&
                   (({1'b0, occ_q} + {1'b0, drop_q}) < (PW+1)'(DEPTH));
  assign accept  = req_vld && bus.IMem_Req_Ready_i;

  assign rsp_drop = bus.IMem_Rsp_Valid_i && (drop_q != '0);
  assign rsp_fill = bus.IMem_Rsp_Valid_i && (drop_q == '0) && (unfilled != '0);
  assign rsp_take = rsp_drop || rsp_fill;

  assign bus.Instr_Valid_o    = (occ_q != '0) && filled_q[head_idx];
  assign deq                  = bus.Instr_Valid_o && bus.Instr_Ready_i;
  assign bus.Instr_o          = data_q[head_idx];
  assign bus.Instr_PC_o       = pc_q[head_idx];
  assign bus.IMem_Req_Valid_o = req_vld;
  assign bus.IMem_Addr_o      = bus.PC_i;

  always_comb begin
    bus.PC_Next_o = bus.PC_i;
    if (!rst)                 bus.PC_Next_o = RESET_PC;
    else if (bus.Redirect_i)  bus.PC_Next_o = bus.Redirect_PC_i & ~WIDTH'(3);
    else if (accept)          bus.PC_Next_o = bus.PC_i + WIDTH'(4);
  end

  always_comb begin
    pc_d        = pc_q;
    data_d      = data_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    occ_d       = occ_q;
    drop_d      = drop_q;

    if (bus.Redirect_i) begin
      // Every unfilled entry has a response still coming; one arriving now is consumed here.
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      occ_d       = '0;
      drop_d      = drop_q + unfilled - ptr_t'(rsp_take);
    end else begin
      if (deq) begin
        filled_d[head_idx] = 1'b0;
        head_ptr_d         = head_ptr_q + ptr_t'(1);
      end
      if (accept) begin
        pc_d[alloc_idx]     = bus.PC_i;
        filled_d[alloc_idx] = 1'b0;
        alloc_ptr_d         = alloc_ptr_q + ptr_t'(1);
      end
      if (rsp_drop) begin
        drop_d = drop_q - ptr_t'(1);
      end else if (rsp_fill) begin
        data_d[fill_idx]   = bus.IMem_Rsp_Data_i;
        filled_d[fill_idx] = 1'b1;
        fill_ptr_d         = fill_ptr_q + ptr_t'(1);
      end
      occ_d = occ_q + ptr_t'(accept) - ptr_t'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      drop_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      data_q      <= data_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      drop_q      <= drop_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC register and in-order memory models, scoreboard of expected decode
// traffic, and a per-cycle model of request eligibility and next-PC.
module tb_instr_fetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic clk;
  logic rst;
  instr_fetch_if #(.WIDTH(32)) bif ();

  instr_fetch #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  exp_t  exp_q[$];
  pend_t pend[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_due = 0;
  bit    in_rst = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: loads the next-PC output every edge.
  always @(posedge clk) bif.PC_i <= bif.PC_Next_o;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Decode-side monitor: compares every transfer against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst) begin
        chk("instr_valid", {31'b0, bif.Instr_Valid_o},
            {31'b0, (exp_q.size() > 0 && exp_q[0].filled)});
        if (bif.Instr_Valid_o && bif.Instr_Ready_i && exp_q.size() > 0) begin
          chk("instr_pc", bif.Instr_PC_o, exp_q[0].pc);
          chk("instr_data", bif.Instr_o, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle(input bit mrdy, input bit drdy, input bit redir,
                       input logic [31:0] tgt, input int lat);
    bit          rsp_now, acc, exp_rv;
    int          total, due;
    logic [31:0] exp_next, pc_now;
    @(negedge clk);
    bif.IMem_Req_Ready_i = mrdy;
    bif.Instr_Ready_i    = drdy;
    bif.Redirect_i       = redir;
    bif.Redirect_PC_i    = tgt;
    rsp_now = pend.size() > 0 && pend[0].due <= cyc;
    bif.IMem_Rsp_Valid_i = rsp_now;
    bif.IMem_Rsp_Data_i  = rsp_now ? mem_word(pend[0].addr) : $urandom;
    #1;
    // Anything requested but not yet handed to decode, live or stale, holds a slot.
    total = exp_q.size();
    foreach (pend[i]) if (pend[i].stale) total++;
    exp_rv = !redir && total < DEPTH;
    pc_now = bif.PC_i;
    chk("req_valid", {31'b0, bif.IMem_Req_Valid_o}, {31'b0, exp_rv});
    chk("req_addr", bif.IMem_Addr_o, pc_now);
    acc = exp_rv && mrdy;
    exp_next = redir ? {tgt[31:2], 2'b00} : (acc ? pc_now + 32'd4 : pc_now);
    chk("pc_next", bif.PC_Next_o, exp_next);
    if (acc) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      exp_q.push_back('{pc: pc_now, data: mem_word(pc_now), filled: 1'b0});
      pend.push_back('{addr: pc_now, due: due, stale: 1'b0});
    end
    #2;
    if (rsp_now) begin
      if (!pend[0].stale) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].filled) begin
            exp_q[i].filled = 1'b1;
            break;
          end
        end
      end
      void'(pend.pop_front());
    end
    if (redir) begin
      exp_q.delete();
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
    end
    cyc++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_instr_valid", {31'b0, bif.Instr_Valid_o}, 32'd0);
    chk("rst_req_valid", {31'b0, bif.IMem_Req_Valid_o}, 32'd0);
    chk("rst_pc_next", bif.PC_Next_o, RESET_PC);
    chk("rst_instr", bif.Instr_o, 32'd0);
    chk("rst_instr_pc", bif.Instr_PC_o, 32'd0);
  endtask

  task automatic quiet_inputs();
    bif.IMem_Req_Ready_i = 1'b0;
    bif.IMem_Rsp_Valid_i = 1'b0;
    bif.IMem_Rsp_Data_i  = '0;
    bif.Redirect_i       = 1'b0;
    bif.Redirect_PC_i    = '0;
    bif.Instr_Ready_i    = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    in_rst = 1'b0;
  endtask

  // Asserted between edges so the asynchronous clear is observable before the next clock.
  task automatic reset_mid();
    @(negedge clk);
    in_rst = 1'b1;
    quiet_inputs();
    #1 rst = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    pend.delete();
    last_due = 0;
    release_reset();
  endtask

  initial begin
    rst = 1'b0;
    quiet_inputs();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    release_reset();

    // Streaming, one-cycle memory, decode always ready.
    repeat (30) cycle(1, 1, 0, 0, 1);

    // Decode stall from PC 0: exactly DEPTH requests, PC holds at 0x10, then drain.
    reset_mid();
    repeat (10) cycle(1, 0, 0, 0, 1);
    repeat (12) cycle(1, 1, 0, 0, 1);

    // Memory backpressure on alternate cycles.
    for (int i = 0; i < 20; i++) cycle(i[0], 1, 0, 0, 1);

    // Redirect with two requests outstanding on a two-cycle memory.
    repeat (6) cycle(1, 1, 0, 0, 2);
    cycle(1, 1, 1, 32'h103, 2);
    repeat (10) cycle(1, 1, 0, 0, 2);

    // Redirect coinciding with a live response on a one-cycle memory.
    repeat (5) cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 32'h200, 1);
    repeat (8) cycle(1, 1, 0, 0, 1);

    // Address wrap past the top of the address space.
    cycle(1, 1, 1, 32'hFFFF_FFF6, 1);
    repeat (8) cycle(1, 1, 0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] t;
      t = ($urandom % 2 == 0) ? 32'h103 : $urandom;
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, t,
            int'($urandom_range(1, 4)));
    end

    // Reset with the buffer full, then restart cleanly.
    repeat (8) cycle(1, 0, 0, 0, 1);
    reset_mid();
    repeat (20) cycle(1, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
